fabric_sram_arbiter: RTL and testbench
======================================

# fabric_sram_arbiter

Arbitrates the shared dual-bank ternary SRAM (weight bank A, input bank B) between the AXI SRAM loader and the frame controller's fetch port, so host writes can overlap a running frame. Frame fetches have priority. Loader writes pass through a one-entry write buffer and are protected by a starvation guard and a read-after-write hazard check. The block sits between the AXI control plane, the frame controller (`mem_ready`) and `ternary_sram_wrapper`, replacing the static `f_start` address mux.

## Interface
- ADDR_W, 12, SRAM word address width
- DATA_W, 24, SRAM word width (three PT-5 bytes)
- STARVE_LIMIT, 8, consecutive cycles a buffered write may be denied before it is forced; must be ≥1
- clk  in  1  fabric clock
- reset  in  1  synchronous, active-high reset
- ld_valid  in  1  loader write request
- ld_ready  out  1  loader write accepted when ld_valid&&ld_ready at the clock edge
- ld_addr  in  ADDR_W  loader word address
- ld_data  in  DATA_W  loader write data
- ld_bank  in  1  0 = weight bank (A), 1 = input bank (B)
- fx_req  in  1  frame controller read request
- fx_addr  in  ADDR_W  fetch address, applied to both banks
- fx_grant  out  1  fetch issued this cycle; drives frame controller mem_ready
- fx_rvalid  out  1  SRAM dout_a/dout_b hold data for the fetch granted the previous cycle
- sram_addr_a / sram_addr_b  out  ADDR_W  bank addresses
- sram_we_a / sram_we_b  out  1  bank write enables
- sram_din  out  DATA_W  write data, common to both banks
- stat_clr  in  1  clears fx_stall_cnt
- fx_stall_cnt  out  16  saturating count of fetch cycles denied

## Operation
- Write buffer registers: buf_full, buf_addr, buf_data, buf_bank. An accepted loader beat loads the buffer.
- hazard = buf_full && fx_req && (buf_addr == fx_addr). Bank is ignored because a fetch reads both banks.
- starve_cnt: 0..STARVE_LIMIT, saturating.
- Grants are combinational each cycle:
  - wr_grant = buf_full && (!fx_req || hazard || starve_cnt == STARVE_LIMIT)
  - fx_grant = fx_req && !wr_grant
  - ld_ready = !buf_full || wr_grant. A drain and a reload may occur in the same cycle.
- SRAM drive when wr_grant:
  - sram_addr_a = sram_addr_b = buf_addr
  - sram_din = buf_data
  - sram_we_a = !buf_bank, sram_we_b = buf_bank
- SRAM drive otherwise: both addresses = fx_addr, both we = 0.
- Buffer update at the clock edge:
  - Load on ld_valid && ld_ready.
  - Else clear buf_full on wr_grant.
  - Else hold.
- starve_cnt update:
  - Cleared on wr_grant or when !buf_full.
  - Otherwise incremented, saturating at STARVE_LIMIT.
- fx_rvalid <= fx_grant.
- fx_stall_cnt:
  - Increments when fx_req && !fx_grant, saturating at 16'hFFFF.
  - stat_clr has priority over increment.
- Ordering: every loader beat accepted before the cycle a fetch is granted is visible to that fetch.

## Timing
- Reset values: buf_full=0, starve_cnt=0, fx_rvalid=0, fx_stall_cnt=0.
- With ld_valid/fx_req low at reset, all combinational outputs are 0: ld_ready=1 because the buffer is empty.
- Reset mid-operation discards a buffered write; it never reaches the SRAM.
- Loader write latency:
  - Accept at edge N, written at edge N+1 if fx_req is low during cycle N+1.
  - Worst case under continuous fetch: written at edge N+1+STARVE_LIMIT.
- Sustained loader throughput is 1 beat/cycle when fx_req is low.
- Read latency: fx_rvalid is high exactly 1 cycle after fx_grant. Grants may be back-to-back.
- A forced write costs the fetch exactly one cycle: fx_grant=0, frame controller holds fx_addr.
- When hazard and starvation coincide, the behaviour is identical: a single write cycle.
- ld_ready and fx_grant depend combinationally on fx_req/fx_addr. Requesters must not make fx_req depend on ld_ready.

## Test plan
- **Reset.** Reset asserted for 2 cycles with ld_valid=1 → ld_ready=1 and no we pulses during reset. After release, fx_stall_cnt=0 and fx_rvalid=0.
- **Idle writes.** 4 loader beats, addr 0x010..0x013, alternating banks, fx_req=0 → one we per cycle on the correct bank, each 1 cycle after acceptance. No loader stall.
- **Starvation, STARVE_LIMIT=8.** Continuous fx_req with a loader beat at addr 0x100 → fx_grant low for exactly one cycle, 9 cycles after acceptance. The write reaches the SRAM in that cycle. fx_stall_cnt=1.
- **RAW hazard.** Buffer holds addr 0x020 (data 0xABCDEF, bank A), then fx_req with fx_addr=0x020 → write issued first. Fetch is granted the next cycle. dout_a = 0xABCDEF when fx_rvalid=1.
- **Non-hazard fetch.** Fetch at 0x021 with a buffered write to 0x020 → fetch granted immediately. The write waits.
- **Counter limits.** Hold fx_req while the writer repeatedly forces slots until fx_stall_cnt reaches 16'hFFFF → the count stays at 16'hFFFF. stat_clr=1 → 0 next cycle, even with a simultaneous stall.

Source files
------------

// File: rtl/fabric_sram_arbiter.sv
// Purpose: shares the dual-bank ternary SRAM between the AXI loader (buffered writes) and frame fetches.
// Latency: fetch data valid 1 cycle after fx_grant; a loader beat is written 1 to 1+STARVE_LIMIT cycles after acceptance.
// Backpressure: ld_ready drops while a buffered write is denied; a forced write drops fx_grant for one cycle.
//
// Ports:
//   clk, reset                     fabric clock, synchronous active-high reset
//   ld_valid/ld_ready/ld_addr/ld_data/ld_bank   loader write beat (valid/ready)
//   fx_req/fx_addr/fx_grant/fx_rvalid           frame-controller fetch port
//   sram_addr_a/b, sram_we_a/b, sram_din        SRAM bank drive
//   stat_clr, fx_stall_cnt         saturating count of denied fetch cycles
`timescale 1ns/1ps
module fabric_sram_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 24,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_bank,
  input  logic              fx_req,
  input  logic [ADDR_W-1:0] fx_addr,
  output logic              fx_grant,
  output logic              fx_rvalid,
  output logic [ADDR_W-1:0] sram_addr_a,
  output logic [ADDR_W-1:0] sram_addr_b,
  output logic              sram_we_a,
  output logic              sram_we_b,
  output logic [DATA_W-1:0] sram_din,
  input  logic              stat_clr,
  output logic [15:0]       fx_stall_cnt
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  logic              buf_full_q, buf_full_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              buf_bank_q, buf_bank_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic              fx_rvalid_q, fx_rvalid_d;
  logic [15:0]       fx_stall_cnt_q, fx_stall_cnt_d;

  logic hazard;
  logic starved;
  logic wr_grant;
  logic ld_fire;

  always_comb begin
    // A fetch reads both banks, so any buffered write to the same word must land first.
    hazard   = buf_full_q && fx_req && (buf_addr_q == fx_addr);
    starved  = (starve_cnt_q == SC_MAX);
    wr_grant = buf_full_q && (!fx_req || hazard || starved);
    fx_grant = fx_req && !wr_grant;
    // Draining the buffer frees it in the same cycle, so a new beat can load behind it.
    ld_ready = !buf_full_q || wr_grant;
    ld_fire  = ld_valid && ld_ready;

    sram_din = buf_data_q;
    if (wr_grant) begin
      sram_addr_a = buf_addr_q;
      sram_addr_b = buf_addr_q;
      sram_we_a   = !buf_bank_q;
      sram_we_b   = buf_bank_q;
    end else begin
      sram_addr_a = fx_addr;
      sram_addr_b = fx_addr;
      sram_we_a   = 1'b0;
      sram_we_b   = 1'b0;
    end

    buf_full_d = buf_full_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    buf_bank_d = buf_bank_q;
    if (ld_fire) begin
      buf_full_d = 1'b1;
      buf_addr_d = ld_addr;
      buf_data_d = ld_data;
      buf_bank_d = ld_bank;
    end else if (wr_grant) begin
      buf_full_d = 1'b0;
    end

    // Counts cycles the current buffered write has been denied.
    if (wr_grant || !buf_full_q) begin
      starve_cnt_d = '0;
    end else if (!starved) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end

    fx_rvalid_d = fx_grant;

    if (stat_clr) begin
      fx_stall_cnt_d = 16'h0000;
    end else if (fx_req && !fx_grant && (fx_stall_cnt_q != 16'hFFFF)) begin
      fx_stall_cnt_d = fx_stall_cnt_q + 16'd1;
    end else begin
      fx_stall_cnt_d = fx_stall_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full_q     <= 1'b0;
      buf_addr_q     <= '0;
      buf_data_q     <= '0;
      buf_bank_q     <= 1'b0;
      starve_cnt_q   <= '0;
      fx_rvalid_q    <= 1'b0;
      fx_stall_cnt_q <= 16'h0000;
    end else begin
      buf_full_q     <= buf_full_d;
      buf_addr_q     <= buf_addr_d;
      buf_data_q     <= buf_data_d;
      buf_bank_q     <= buf_bank_d;
      starve_cnt_q   <= starve_cnt_d;
      fx_rvalid_q    <= fx_rvalid_d;
      fx_stall_cnt_q <= fx_stall_cnt_d;
    end
  end

  assign fx_rvalid    = fx_rvalid_q;
  assign fx_stall_cnt = fx_stall_cnt_q;

endmodule

// File: tb/tb_fabric_sram_arbiter.sv
// Purpose: scoreboard bench for fabric_sram_arbiter with a behavioural dual-bank SRAM.
// Latency: expected SRAM writes carry the cycle they must appear in; reads expect data 1 cycle after grant.
// Backpressure: ld_ready and fx_grant are compared against hand-derived values every stimulus cycle.
`timescale 1ns/1ps
module tb_fabric_sram_arbiter;
  localparam int AW = 12;
  localparam int DW = 24;
  localparam int SL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_valid, ld_ready, ld_bank;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          fx_req, fx_grant, fx_rvalid;
  logic [AW-1:0] fx_addr;
  logic [AW-1:0] sram_addr_a, sram_addr_b;
  logic          sram_we_a, sram_we_b;
  logic [DW-1:0] sram_din;
  logic          stat_clr;
  logic [15:0]   fx_stall_cnt;

  always #5 clk = ~clk;

  fabric_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_bank(ld_bank),
    .fx_req(fx_req), .fx_addr(fx_addr), .fx_grant(fx_grant), .fx_rvalid(fx_rvalid),
    .sram_addr_a(sram_addr_a), .sram_addr_b(sram_addr_b),
    .sram_we_a(sram_we_a), .sram_we_b(sram_we_b), .sram_din(sram_din),
    .stat_clr(stat_clr), .fx_stall_cnt(fx_stall_cnt)
  );

  // Synchronous-read SRAM banks, read-old-data on a write cycle.
  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];
  logic [DW-1:0] dout_a, dout_b;
  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      mem_a[i] <= '0;
      mem_b[i] <= '0;
    end
  end
  always @(posedge clk) begin
    if (sram_we_a) mem_a[sram_addr_a] <= sram_din;
    if (sram_we_b) mem_b[sram_addr_b] <= sram_din;
    dout_a <= mem_a[sram_addr_a];
    dout_b <= mem_b[sram_addr_b];
  end

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [79:0] rd_q[$];
  wr_exp_t     w;
  logic [79:0] r;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_stall = 16'h0000;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every SRAM write and every fx_rvalid must match the next queued expectation.
  always @(negedge clk) begin
    if (sram_we_a || sram_we_b) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", 96'({sram_we_a, sram_we_b, sram_addr_a, sram_din}), 96'(0));
      end else begin
        w = wr_q.pop_front();
        check("sram_write",
              96'({sram_we_a, sram_we_b, sram_addr_a, sram_addr_b, sram_din, cyc}),
              96'({~w.bank, w.bank, w.addr, w.addr, w.data, w.cyc}));
      end
    end
    if (fx_rvalid) begin
      if (rd_q.size() == 0) begin
        check("unexpected_rvalid", 96'({dout_a, dout_b}), 96'(0));
      end else begin
        r = rd_q.pop_front();
        check("fetch_data", 96'({dout_a, dout_b, cyc}), 96'(r));
      end
    end
  end

  // One stimulus cycle: drive, then check handshakes and push expectations.
  task automatic step(input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd, input logic lb,
                      input logic fr, input logic [AW-1:0] fa, input logic sc,
                      input logic exp_lr, input logic exp_fg,
                      input logic [DW-1:0] ra, input logic [DW-1:0] rb, input int wr_dly);
    @(posedge clk); #1;
    ld_valid = lv; ld_addr = la; ld_data = ldd; ld_bank = lb;
    fx_req = fr; fx_addr = fa; stat_clr = sc;
    @(negedge clk);
    check("ld_ready", 96'(ld_ready), 96'(exp_lr));
    check("fx_grant", 96'(fx_grant), 96'(exp_fg));
    check("fx_stall_cnt", 96'(fx_stall_cnt), 96'(exp_stall));
    if (exp_fg) rd_q.push_back({ra, rb, cyc + 32'd1});
    if (lv && exp_lr && wr_dly > 0) wr_q.push_back('{bank: lb, addr: la, data: ldd, cyc: cyc + 32'(wr_dly)});
    if (sc) exp_stall = 16'h0000;
    else if (fr && !exp_fg && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
  endtask

  task automatic idle(input logic exp_lr);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, exp_lr, 1'b0, '0, '0, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] last_d;

  initial begin
    reset = 1'b1; ld_valid = 1'b1; ld_addr = 12'h0AA; ld_data = 24'h123456; ld_bank = 1'b0;
    fx_req = 1'b0; fx_addr = '0; stat_clr = 1'b0;
    // Reset with a pending loader beat: ready, but nothing written.
    @(posedge clk); @(negedge clk);
    check("reset_ld_ready", 96'(ld_ready), 96'(1));
    check("reset_no_we", 96'({sram_we_a, sram_we_b}), 96'(0));
    @(posedge clk); #1;
    reset = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    check("post_reset_stall", 96'(fx_stall_cnt), 96'(0));
    check("post_reset_rvalid", 96'(fx_rvalid), 96'(0));
    check("post_reset_no_we", 96'({sram_we_a, sram_we_b, fx_grant}), 96'(0));
    check("post_reset_ld_ready", 96'(ld_ready), 96'(1));

    // Idle writes: 1 beat/cycle, each written the cycle after acceptance.
    for (int i = 0; i < 4; i++)
      step(1'b1, 12'h010 + 12'(i), 24'hD00010 + 24'(i), i[0], 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1);
    idle(1'b1);
    // Read back 0x011 (bank B data) and 0x012 (bank A data).
    step(1'b0, '0, '0, 1'b0, 1'b1, 12'h011, 1'b0, 1'b1, 1'b1, 24'h000000, 24'hD00011, 0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 12'h012, 1'b0, 1'b1, 1'b1, 24'hD00012, 24'h000000, 0);
    idle(1'b1);

    // Starvation: forced write exactly STARVE_LIMIT+1 cycles after the accept cycle.
    step(1'b1, 12'h100, 24'h5A5A5A, 1'b0, 1'b1, 12'h200, 1'b0, 1'b1, 1'b1, '0, '0, SL + 1);
    for (int i = 0; i < SL; i++)
      step(1'b0, '0, '0, 1'b0, 1'b1, 12'h200, 1'b0, 1'b0, 1'b1, '0, '0, 0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 12'h200, 1'b0, 1'b1, 1'b0, '0, '0, 0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 12'h200, 1'b0, 1'b1, 1'b1, '0, '0, 0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 12'h100, 1'b0, 1'b1, 1'b1, 24'h5A5A5A, '0, 0);
    idle(1'b1);

    // Non-hazard fetch proceeds, then RAW hazard drains the write first.
    step(1'b1, 12'h020, 24'hABCDEF, 1'b0, 1'b1, 12'h021, 1'b0, 1'b1, 1'b1, '0, '0, 2);
    step(1'b0, '0, '0, 1'b0, 1'b1, 12'h021, 1'b0, 1'b0, 1'b1, '0, '0, 0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 12'h020, 1'b0, 1'b1, 1'b0, '0, '0, 0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 12'h020, 1'b0, 1'b1, 1'b1, 24'hABCDEF, '0, 0);
    idle(1'b1);
    idle(1'b1);

    // Counter limits: a hazard write every cycle stalls the fetch every cycle.
    last_d = '0;
    for (int i = 0; i < 65540; i++) begin
      last_d = 24'h5A0000 ^ 24'(i);
      step(1'b1, 12'h300, last_d, 1'b0, 1'b1, 12'h300, 1'b0, 1'b1, (i == 0), '0, '0, 1);
    end
    // Clear coincides with a stall; the count reads 0 the next cycle.
    step(1'b0, '0, '0, 1'b0, 1'b1, 12'h300, 1'b1, 1'b1, 1'b0, '0, '0, 0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 12'h300, 1'b0, 1'b1, 1'b1, last_d, '0, 0);
    idle(1'b1);
    idle(1'b1);

    check("wr_q_drained", 96'(wr_q.size()), 96'(0));
    check("rd_q_drained", 96'(rd_q.size()), 96'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
